// File: rtl/artec_dma_frame_sched.sv
// Frame scheduler: issues one write descriptor per enabled channel (round-robin on
// readiness) into the current frame buffer, then a status word, then advances buffers.
module artec_dma_frame_sched #(
    parameter int CH_NUM = 6,
    parameter int FB_NUM = 8,
    localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    localparam int FW = $clog2(FB_NUM)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 clear_i,
    input  logic                 stsclr_i,
    input  logic [FB_NUM*32-1:0] fb_addr_i,
    input  logic [31:0]          status_addr_i,
    input  logic [CH_NUM-1:0]    ch_enable_i,
    input  logic [CH_NUM*32-1:0] ch_offset_i,
    input  logic [CH_NUM*32-1:0] ch_size_i,
    input  logic [CH_NUM-1:0]    ch_req_i,
    output logic                 desc_valid_o,
    input  logic                 desc_ready_i,
    output logic [31:0]          desc_addr_o,
    output logic [31:0]          desc_len_o,
    output logic [CW-1:0]        desc_ch_o,
    input  logic                 done_i,
    output logic                 stat_valid_o,
    input  logic                 stat_ready_i,
    output logic [31:0]          stat_addr_o,
    output logic [31:0]          stat_data_o,
    output logic                 busy_o,
    output logic                 stop_o,
    output logic [31:0]          frame_number_o,
    output logic [FB_NUM-1:0]    frame_status_o
);

    localparam int unsigned CHN = CH_NUM;
    localparam int unsigned FBN = FB_NUM;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_ISSUE, S_WAIT, S_STATUS} state_t;

    state_t              state_q, state_d;
    logic [CH_NUM-1:0]   pend_q, pend_d;
    logic [CW-1:0]       rr_q, rr_d;
    logic [FW-1:0]       fb_q, fb_d;
    logic                stop_pend_q, stop_pend_d;
    logic                desc_valid_d, stat_valid_d, stop_d;
    logic [31:0]         desc_addr_d, desc_len_d, stat_addr_d, stat_data_d, frame_number_d;
    logic [CW-1:0]       desc_ch_d;
    logic [FB_NUM-1:0]   frame_status_d;
    logic                fs_set;

    logic [31:0]         fb_addr [FB_NUM];
    logic [31:0]         ch_off  [CH_NUM];
    logic [31:0]         ch_size [CH_NUM];
    logic                gnt_found;
    logic [CW-1:0]       gnt_ch;
    logic [CW-1:0]       cand;
    int unsigned         idx;

    always_comb begin
        for (int unsigned i = 0; i < FBN; i++) fb_addr[i] = fb_addr_i[32*i +: 32];
        for (int unsigned i = 0; i < CHN; i++) begin
            ch_off[i]  = ch_offset_i[32*i +: 32];
            ch_size[i] = ch_size_i[32*i +: 32];
        end
    end

    // First pending-and-ready channel searching upward from rr, wrapping at CH_NUM.
    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = '0;
        cand      = '0;
        idx       = 0;
        for (int unsigned i = 0; i < CHN; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= CHN) idx = idx - CHN;
            cand = CW'(idx);
            if (!gnt_found && pend_q[cand] && ch_req_i[cand]) begin
                gnt_found = 1'b1;
                gnt_ch    = cand;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        rr_d           = rr_q;
        fb_d           = fb_q;
        stop_pend_d    = stop_pend_q;
        desc_valid_d   = desc_valid_o;
        desc_addr_d    = desc_addr_o;
        desc_len_d     = desc_len_o;
        desc_ch_d      = desc_ch_o;
        stat_valid_d   = stat_valid_o;
        stat_addr_d    = stat_addr_o;
        stat_data_d    = stat_data_o;
        frame_number_d = frame_number_o;
        stop_d         = 1'b0;
        fs_set         = 1'b0;

        if (state_q != S_IDLE && stop_i) stop_pend_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (stop_i) begin
                    stop_d = 1'b1;
                end else if (start_i) begin
                    pend_d  = ch_enable_i;
                    rr_d    = '0;
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (pend_q == '0) begin
                    state_d      = S_STATUS;
                    stat_valid_d = 1'b1;
                    stat_addr_d  = status_addr_i + {{(30-FW){1'b0}}, fb_q, 2'b00};
                    stat_data_d  = {frame_number_o[23:0], {(8-FW){1'b0}}, fb_q};
                end else if (gnt_found) begin
                    pend_d[gnt_ch] = 1'b0;
                    rr_d = (gnt_ch == CW'(CHN - 1)) ? '0 : gnt_ch + 1'b1;
                    if (ch_size[gnt_ch] != '0) begin
                        state_d      = S_ISSUE;
                        desc_valid_d = 1'b1;
                        desc_addr_d  = fb_addr[fb_q] + ch_off[gnt_ch];
                        desc_len_d   = ch_size[gnt_ch];
                        desc_ch_d    = gnt_ch;
                    end
                end
            end
            S_ISSUE: begin
                if (desc_ready_i) begin
                    desc_valid_d = 1'b0;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_i) state_d = S_ARB;
            end
            S_STATUS: begin
                if (stat_ready_i) begin
                    stat_valid_d   = 1'b0;
                    frame_number_d = frame_number_o + 32'd1;
                    fs_set         = 1'b1;
                    fb_d           = fb_q + 1'b1;
                    if (stop_pend_q || stop_i) begin
                        state_d     = S_IDLE;
                        stop_d      = 1'b1;
                        stop_pend_d = 1'b0;
                    end else begin
                        pend_d  = ch_enable_i;
                        rr_d    = '0;
                        state_d = S_ARB;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        frame_status_d = frame_status_o;
        if (stsclr_i) frame_status_d = '0;
        if (fs_set) frame_status_d[fb_q] = 1'b1;

        if (clear_i) begin
            state_d        = S_IDLE;
            pend_d         = '0;
            rr_d           = '0;
            fb_d           = '0;
            stop_pend_d    = 1'b0;
            desc_valid_d   = 1'b0;
            stat_valid_d   = 1'b0;
            stop_d         = 1'b0;
            frame_number_d = '0;
            frame_status_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            pend_q         <= '0;
            rr_q           <= '0;
            fb_q           <= '0;
            stop_pend_q    <= 1'b0;
            desc_valid_o   <= 1'b0;
            desc_addr_o    <= '0;
            desc_len_o     <= '0;
            desc_ch_o      <= '0;
            stat_valid_o   <= 1'b0;
            stat_addr_o    <= '0;
            stat_data_o    <= '0;
            busy_o         <= 1'b0;
            stop_o         <= 1'b0;
            frame_number_o <= '0;
            frame_status_o <= '0;
        end else begin
            state_q        <= state_d;
            pend_q         <= pend_d;
            rr_q           <= rr_d;
            fb_q           <= fb_d;
            stop_pend_q    <= stop_pend_d;
            desc_valid_o   <= desc_valid_d;
            desc_addr_o    <= desc_addr_d;
            desc_len_o     <= desc_len_d;
            desc_ch_o      <= desc_ch_d;
            stat_valid_o   <= stat_valid_d;
            stat_addr_o    <= stat_addr_d;
            stat_data_o    <= stat_data_d;
            busy_o         <= (state_d != S_IDLE);
            stop_o         <= stop_d;
            frame_number_o <= frame_number_d;
            frame_status_o <= frame_status_d;
        end
    end

endmodule

// File: doc/artec_dma_frame_sched.md
# artec_dma_frame_sched

Frame scheduler for the AXIS-to-AXI DMA. It sits between the APB settings block and the AXI write engine, and sequences one frame at a time into the current frame buffer. For each enabled channel it issues one write descriptor, granting channels round-robin as their data becomes ready. After the last channel it posts a status-word write, then advances to the next frame buffer. It owns the start/stop/finish handshake and the frame counter.

## Interface
- CH_NUM, 6, number of stream channels (1..16)
- FB_NUM, 8, number of frame buffers (power of two, 2..16)
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start_i / stop_i / clear_i  in  1 each  single-cycle pulses from the settings block
- stsclr_i  in  1  clears frame_status_o
- fb_addr_i  in  FB_NUM*32  frame buffer base addresses, entry i at [32i+:32]
- status_addr_i  in  32  base address of the status array
- ch_enable_i  in  CH_NUM  channel enable mask
- ch_offset_i / ch_size_i  in  CH_NUM*32 each  per-channel byte offset and byte length
- ch_req_i  in  CH_NUM  channel has a full frame slice buffered
- desc_valid_o  out  1  descriptor valid; desc_ready_i  in  1  engine accepts
- desc_addr_o  out  32; desc_len_o  out  32; desc_ch_o  out  $clog2(CH_NUM)
- done_i  in  1  pulse: outstanding descriptor fully written
- stat_valid_o  out  1; stat_ready_i  in  1; stat_addr_o  out  32; stat_data_o  out  32
- busy_o  out  1  state != IDLE
- stop_o  out  1  pulse: scheduler has halted (feeds finish)
- frame_number_o  out  32  completed-frame count
- frame_status_o  out  FB_NUM  sticky bit per buffer written

## Operation
- States: IDLE, ARB, ISSUE, WAIT, STATUS.
- IDLE: on start_i, latch ch_enable_i into the pending mask, clear the rr pointer to 0, and go to ARB.
- ARB: pending zero -> STATUS. Otherwise grant the first channel c at or after rr (wrapping) with pending[c] & ch_req_i[c].
  - No candidate: stay in ARB.
  - Granted with ch_size_i[c]==0: clear pending[c], set rr=c+1, stay in ARB, issue no descriptor.
  - Granted otherwise: register desc_addr = fb_addr[fb_idx]+ch_offset[c] (mod 2^32), desc_len = ch_size[c], desc_ch = c; clear pending[c]; set rr=c+1 (mod CH_NUM); go to ISSUE.
- ISSUE: desc_valid_o=1 with all descriptor fields stable until desc_ready_i, then go to WAIT.
- WAIT: on done_i go to ARB. done_i is ignored in every other state. Only one descriptor is outstanding at a time.
- STATUS: stat_valid_o=1, stat_addr_o = status_addr_i + 4*fb_idx, stat_data_o = {frame_number_o[23:0], 8'(fb_idx)}. On stat_ready_i:
  - frame_number_o += 1 (wraps at 2^32);
  - set frame_status_o[fb_idx];
  - fb_idx = (fb_idx+1) mod FB_NUM;
  - stop pending -> IDLE and pulse stop_o; else reload the pending mask from ch_enable_i, clear rr to 0, and go to ARB.
- stop_i outside IDLE sets stop pending; the current frame completes normally. stop_i in IDLE pulses stop_o the next cycle.
- start_i outside IDLE is ignored. start_i and stop_i together in IDLE: stop wins and no frame starts.
- clear_i (any state) forces IDLE and zeroes fb_idx, frame_number_o, frame_status_o, stop pending, pending, rr and all valids. The outstanding descriptor is abandoned. The system issues clear only after stop_o.
- stsclr_i zeroes frame_status_o. A same-cycle set wins over stsclr_i.

## Timing
- Reset values:
  - state IDLE; all *_valid_o, busy_o and stop_o = 0;
  - desc_* = 0, stat_* = 0;
  - frame_number_o = 0, frame_status_o = 0, fb_idx = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- start_i at cycle t -> ARB at t+1. With ch_req_i high, desc_valid_o rises at t+2.
- Descriptor latency: grant to desc_valid_o is 1 cycle. Each zero-size skip costs 1 ARB cycle.
- Status latency: done_i of the last channel at t -> ARB at t+1 -> stat_valid_o at t+2.
- stop_o is exactly one cycle wide, in the cycle after the status handshake (or after stop_i in IDLE). busy_o falls in the same cycle.
- Valid/ready: a valid, once raised, is not withdrawn and its data does not change until the handshake, except on clear_i.

## Test plan
- Enables 0b000101, all req high, fb_addr[0]=0x1000_0000, offset[0]=0x0, offset[2]=0x200, sizes 0x100/0x80, status_addr=0x2000_0000 -> descriptors (0x1000_0000,0x100,ch0) then (0x1000_0200,0x80,ch2); status write addr 0x2000_0000, data 0x0000_0000; frame_number 1; frame_status 0x01.
- Round-robin: ch1 req late and ch3 req early -> ch3 is granted before ch1. desc_ready_i held low for 5 cycles -> fields stable throughout.
- Run 9 frames with FB_NUM=8 -> status addresses step by 4 and wrap to index 0 at frame 9; stat_data of frame 9 = 0x0000_0800.
- stop_i mid-WAIT -> remaining channels complete, status is written, stop_o pulses once, busy_o=0; a subsequent done_i has no effect.
- Enable mask 0 -> status write only. ch_size 0 on an enabled channel -> no descriptor for it.
- clear_i during ISSUE -> next cycle desc_valid_o=0, IDLE, frame_number=0, frame_status=0, fb_idx=0. rstn asserted mid-frame gives the same result asynchronously.
